// File: rtl/equiv_gen_pkg.sv
// Shared types and constants for the equivalence-pair generator.
//   state_e      : output-stage occupancy (StEmpty / StFull)
//   LfsrTap      : Galois right-shift feedback mask
//   DefaultSeed  : reset seed, also used when a zero seed is loaded
//   bit_reverse  : mirrors the low n bits of a vector
package equiv_gen_pkg;

    typedef enum logic {
        StEmpty = 1'b0,
        StFull  = 1'b1
    } state_e;

    localparam int unsigned MaxRevW     = 16;
    localparam int unsigned RevIdxW     = $clog2(MaxRevW);
    localparam logic [15:0] LfsrTap     = 16'hB400;
    localparam logic [15:0] DefaultSeed = 16'hACE1;

    // Reverses bits [n-1:0] of v into bits [n-1:0] of the result; upper bits are zero.
    function automatic logic [MaxRevW-1:0] bit_reverse(input logic [MaxRevW-1:0] v,
                                                       input int unsigned         n);
        logic [MaxRevW-1:0] r;
        r = '0;
        for (int unsigned i = 0; i < MaxRevW; i++) begin
            if (i < n) begin
                r[RevIdxW'(n - 1 - i)] = v[RevIdxW'(i)];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/equiv_lfsr.sv
// Galois right-shift LFSR with synchronous load and zero-seed protection.
//   clk, rstN      : clock, asynchronous active-low reset (resets to SEED)
//   load_i         : load load_value_i (or SEED if load_value_i is zero); wins over advance
//   load_value_i   : seed to load
//   advance_i      : step the LFSR once
//   value_o        : current LFSR state
module equiv_lfsr #(
    parameter int unsigned       LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
    parameter logic [LFSR_W-1:0] TAP    = 16'hB400
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              load_i,
    input  logic [LFSR_W-1:0] load_value_i,
    input  logic              advance_i,
    output logic [LFSR_W-1:0] value_o
);

    logic [LFSR_W-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            // An all-zero state would lock the LFSR up, so substitute the default seed.
            lfsr_d = (load_value_i == '0) ? SEED : load_value_i;
        end else if (advance_i) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAP : '0);
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value_o = lfsr_q;

endmodule

// File: rtl/equiv_pair_gen.sv
// Generates a pseudo-random operand pair (d1, d2) whose truth values match a
// requested equivalence result: ((|d1) == (|d2)) == req_equiv.
//   clk, rstN              : clock, asynchronous active-low reset
//   seed_load, seed_value  : synchronous reseed; overrides all handshakes that cycle
//   req_valid/req_ready    : request handshake, req_equiv carries the wanted result
//   out_valid/out_ready    : output handshake for d1, d2, out_equiv
//   pair_count             : number of pairs consumed, wrapping 16-bit counter
module equiv_pair_gen
    import equiv_gen_pkg::*;
#(
    parameter int unsigned       N      = 8,
    parameter int unsigned       LFSR_W = 16,
    parameter logic [LFSR_W-1:0] SEED   = DefaultSeed
) (
    input  logic              clk,
    input  logic              rstN,
    input  logic              seed_load,
    input  logic [LFSR_W-1:0] seed_value,
    input  logic              req_valid,
    input  logic              req_equiv,
    output logic              req_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N-1:0]      d1,
    output logic [N-1:0]      d2,
    output logic              out_equiv,
    output logic [15:0]       pair_count
);

    state_e            state_q, state_d;
    logic [N-1:0]      d1_q, d1_d;
    logic [N-1:0]      d2_q, d2_d;
    logic              equiv_q, equiv_d;
    logic [15:0]       count_q, count_d;

    logic              accept;
    logic              xfer;
    logic [LFSR_W-1:0] lfsr_val;

    // Request handshake
    assign req_ready = !seed_load && ((state_q == StEmpty) || out_ready);
    assign accept    = req_valid && req_ready;
    assign xfer      = (state_q == StFull) && out_ready;

    equiv_lfsr #(
        .LFSR_W (LFSR_W),
        .SEED   (SEED),
        .TAP    (LFSR_W'(LfsrTap))
    ) u_lfsr (
        .clk          (clk),
        .rstN         (rstN),
        .load_i       (seed_load),
        .load_value_i (seed_value),
        .advance_i    (accept),
        .value_o      (lfsr_val)
    );

    // Pair forming from the pre-advance LFSR value
    logic               z1;
    logic               t2;
    logic [N-1:0]       lo;
    logic [N-1:0]       nz;
    logic [MaxRevW-1:0] rev_full;
    logic [N-1:0]       nz_rev;
    logic [N-1:0]       gen_d1;
    logic [N-1:0]       gen_d2;

    // Top two LFSR bits zero (~1/4 of states) forces d1 to zero.
    assign z1       = (lfsr_val[LFSR_W-1 -: 2] == 2'b00);
    assign lo       = lfsr_val[N-1:0];
    // Non-zero operand value: zero low bits would make a "true" operand false.
    assign nz       = (lo == '0) ? N'(1) : lo;
    assign rev_full = bit_reverse(MaxRevW'(nz), N);
    assign nz_rev   = rev_full[N-1:0];
    assign gen_d1   = z1 ? '0 : nz;
    // d2 is true exactly when its truth value must match (equiv) or oppose (differ) d1.
    assign t2       = req_equiv ? !z1 : z1;
    assign gen_d2   = t2 ? nz_rev : '0;

    // Bits not consumed by pair forming.
    logic [LFSR_W-1:0]  lfsr_unused;
    logic [MaxRevW-1:0] rev_unused;
    assign lfsr_unused = lfsr_val;
    assign rev_unused  = rev_full;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        d1_d    = d1_q;
        d2_d    = d2_q;
        equiv_d = equiv_q;
        count_d = count_q;

        if (seed_load) begin
            // Reseed discards any pending pair without counting it.
            state_d = StEmpty;
        end else begin
            if (xfer) begin
                count_d = count_q + 16'd1;
            end
            if (accept) begin
                state_d = StFull;
                d1_d    = gen_d1;
                d2_d    = gen_d2;
                equiv_d = req_equiv;
            end else if (xfer) begin
                state_d = StEmpty;
            end
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q <= StEmpty;
            d1_q    <= '0;
            d2_q    <= '0;
            equiv_q <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
            equiv_q <= equiv_d;
            count_q <= count_d;
        end
    end

    assign out_valid  = (state_q == StFull);
    assign d1         = d1_q;
    assign d2         = d2_q;
    assign out_equiv  = equiv_q;
    assign pair_count = count_q;

endmodule
